// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^M) constants and exponentiation FSM state encoding.
package gf_pkg;
  localparam int GF_M = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int GF_ONE = 1;
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} gf_state_t;
endpackage

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^M) multiplier, shift-and-add with per-step reduction by POLY.
module gf_mul #(
  parameter int M = 8,
  parameter logic [M:0] POLY = 9'h11D
) (
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_p
);
  logic [M-1:0] w_p;
  always_comb begin
    w_p = '0;
    for (int i = M - 1; i >= 0; i--)
      w_p = (w_p << 1) ^ (w_p[M-1] ? POLY[M-1:0] : '0) ^ (i_b[i] ? i_a : '0);
  end
  assign o_p = w_p;
endmodule

// File: rtl/gf_pow_unit.sv
// gf_pow_unit: multi-cycle GF(2^M) a^e / inverse via MSB-first square-and-multiply.
// Define GF_POW_ZERO_CHK_EN to flag an inverse-of-zero request on o_err.
module gf_pow_unit
  import gf_pkg::*;
#(
  parameter int M = GF_M,
  parameter logic [M:0] POLY = GF_POLY,
  parameter int EW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_inv,
  input  logic [M-1:0]  i_a,
  input  logic [EW-1:0] i_e,
  output logic          o_ready,
  output logic          o_done,
  output logic [M-1:0]  o_q,
  output logic          o_err
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [EW-1:0] INV_EXP = EW'((64'd1 << M) - 64'd2);
  gf_state_t     r_state, w_next;
  logic [M-1:0]  r_base, r_acc, r_q, w_prod, w_mul_b, w_mul_res;
  logic [EW-1:0] r_exp;
  logic [IW-1:0] r_idx;
  logic          w_last;
  assign w_mul_b   = (r_state == MUL) ? r_base : r_acc;
  assign w_mul_res = r_exp[r_idx] ? w_prod : r_acc;
  assign w_last    = (r_idx == '0);
  gf_mul #(.M(M), .POLY(POLY)) u_mul (.i_a(r_acc), .i_b(w_mul_b), .o_p(w_prod));
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (i_start ? SQR : IDLE) :
             (r_state == SQR)  ? MUL :
             (r_state == MUL)  ? (w_last ? DONE : SQR) : IDLE;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_base <= '0;
      r_exp  <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_q    <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_base <= i_a;
      r_exp  <= i_inv ? INV_EXP : i_e;
      r_acc  <= M'(GF_ONE);
      r_idx  <= IW'(EW - 1);
    end else if (r_state == SQR) begin
      r_acc  <= w_prod;
    end else if (r_state == MUL) begin
      r_acc  <= w_mul_res;
      r_idx  <= r_idx - 1'b1;
      if (w_last) r_q <= w_mul_res;
    end
`ifdef GF_POW_ZERO_CHK_EN
  logic r_zflag, r_err;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_zflag <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_zflag <= i_inv & (i_a == '0);
    end else if (r_state == MUL && w_last) begin
      r_err   <= r_zflag;
    end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
  // q/err are loaded on the edge entering DONE so they are valid alongside done
  assign o_ready = (r_state == IDLE);
  assign o_done  = (r_state == DONE);
  assign o_q     = r_q;
endmodule

// File: doc/gf_pow_unit.md
# gf_pow_unit

Sequential GF(2^M) exponentiation engine for the ECC datapath. It computes q = a^e, or the field inverse a^(2^M−2), by MSB-first square-and-multiply over a single shared field multiplier. It sits beside the syndrome and error-locator logic. It replaces the fixed-field, 8-bit combinational squaring stage with a parametrised, multi-cycle unit that supports any field width and polynomial.

## Interface
- M, 8: field width in bits.
- POLY, 9'h11D: primitive polynomial, M+1 bits, bit M set.
- EW, 8: exponent width in bits; must be ≥ M when inverse mode is used.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when ready=1.
- inv  in  1  sampled with start; 1 = compute inverse and ignore e.
- a  in  M  base operand, sampled with start.
- e  in  EW  exponent, sampled with start.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse when q is updated.
- q  out  M  result; holds until the next done.
- err  out  1  inverse of zero requested; valid with done.

## Operation
- States: IDLE, SQR, MUL, DONE.
- IDLE (ready=1), on start: latch base=a and exp = inv ? (2^M−2) : e, zero-extended to EW. Set acc=1, idx=EW−1, zflag = inv & (a==0). Go to SQR.
- SQR: acc ← acc·acc. Go to MUL.
- MUL: if exp[idx]=1 then acc ← acc·base, else acc holds. If idx==0 go to DONE, else idx−1 and go to SQR.
- DONE: q ← acc, err ← zflag, done=1. Go to IDLE.
- Arithmetic is carry-less. A product is reduced modulo POLY to M bits.
- One multiplier instance. The operand mux selects (acc,acc) in SQR and (acc,base) in MUL.
- Every exponent bit costs both a SQR and a MUL cycle, so latency is data-independent.
- Boundary cases:
  - e=0 gives q=1, including for a=0.
  - a=0 with e≠0 gives q=0.
  - inv with a=0 gives q=0 and err per Configuration.
- start while ready=0 is ignored, with no queuing and no effect on the operation in flight.
- inv and e are sampled only at acceptance; later changes have no effect.

## Timing
- Reset values: ready=1, done=0, q=0, err=0, state=IDLE.
- start accepted at edge T; ready falls after T; done=1 in cycle T+2·EW+1. With EW=8, done appears 17 cycles after acceptance.
- ready returns to 1 in the cycle after done. A new start in that cycle is accepted.
- q and err change only on the DONE edge and on reset.
- Reset mid-operation aborts at once: all outputs return to reset values and no done is produced.

## Configuration
- GF_POW_ZERO_CHK_EN defined: err=1 with done when inv=1 and a=0; q=0.
- GF_POW_ZERO_CHK_EN undefined: zflag logic is removed and err is tied to 0. q is still 0 for an inverse of zero, since 0^(2^M−2)=0.

## Structure
- Shared package gf_pkg holds:
  - the default M and POLY constants;
  - the state-encoding typedef for IDLE/SQR/MUL/DONE;
  - the helper constant GF_ONE = 1.
- One sub-module, gf_mul. It is a combinational M-bit multiplier parametrised by M and POLY, with shift-and-add and per-step reduction. It is instantiated once.

## Test plan
All scenarios use M=8, POLY=0x11D, EW=8.
- Square: start, a=0x80, e=2 → done at T+17, q=0x13, err=0. Then a=0x03, e=2 → q=0x05.
- Inverse: a=0x02, inv=1 → q=0x8E. Group order: a=0x02, e=0xFF → q=0x01.
- Zero cases: a=0x00, e=0 → q=0x01. a=0x00, inv=1 → q=0x00, err=1 with the macro defined and err=0 without it.
- Busy: start, a=0x02, e=0x08. Pulse start again at T+5 with a=0x55. The second start is ignored; a single done at T+17 gives q=0x1D. ready is 1 at T+18.
- Reset: assert reset at T+9 of an operation → ready=1, q=0, done=0, and no done pulse follows. Issue a fresh start → correct result after 17 cycles.
- Random: 1000 random (a, e, inv) requests checked against a reference model. done must always arrive exactly 2·EW+1 cycles after acceptance.
